sc_mult_sequencer: RTL and testbench

//  Controller for the stochastic-multiply datapath (2x LFSR, comparators, XNOR multiplier).

---
 rtl/sc_pkg.sv | 31 +++
 rtl/sc_ones_counter.sv | 26 ++
 rtl/sc_mult_sequencer.sv | 122 ++++++++++++
 tb/tb_sc_mult_sequencer.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/sc_pkg.sv
// rtl/sc_pkg.sv - shared states, defaults and length decode for the stochastic-multiply sequencer
package sc_pkg;

    localparam int PIPE_LAT_DEF = 2;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SEED  = 3'd1;
    localparam logic [2:0] S_FILL  = 3'd2;
    localparam logic [2:0] S_COUNT = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    typedef enum logic [2:0] {
        IDLE  = S_IDLE,
        SEED  = S_SEED,
        FILL  = S_FILL,
        COUNT = S_COUNT,
        DONE  = S_DONE
    } sc_state_e;

    // Stream length 2^(3+len_sel), saturated at the longest supported stream.
    function automatic int unsigned len_decode(input logic [1:0] len_sel,
                                               input int unsigned max_log2);
        int unsigned e;
        e = 32'd3 + 32'(len_sel);
        if (e > max_log2) begin
            e = max_log2;
        end
        return 32'd1 << e;
    endfunction

endpackage

// File: rtl/sc_ones_counter.sv
// rtl/sc_ones_counter.sv - clearable, enabled up-counter for product-stream ones
module sc_ones_counter #(
    parameter int W = 7
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_clr,
    input  logic         i_en,
    output logic [W-1:0] o_count
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + W'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/sc_mult_sequencer.sv
// rtl/sc_mult_sequencer.sv - job sequencer for the stochastic multiplier; optional SC_BIPOLAR_DECODE_EN adds res_bipolar
module sc_mult_sequencer
    import sc_pkg::*;
#(
    parameter int MAX_LEN_LOG2 = 6,
    parameter int PIPE_LAT     = PIPE_LAT_DEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start_valid,
    output logic                      start_ready,
    input  logic [3:0]                op_a,
    input  logic [3:0]                op_b,
    input  logic [1:0]                len_sel,
    output logic [3:0]                dp_prob_a,
    output logic [3:0]                dp_prob_b,
    output logic                      dp_load,
    output logic                      dp_en,
    input  logic                      dp_bit,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic [MAX_LEN_LOG2:0]     res_count,
`ifdef SC_BIPOLAR_DECODE_EN
    output logic signed [MAX_LEN_LOG2+1:0] res_bipolar,
`endif
    output logic                      busy
);

    localparam int CW = MAX_LEN_LOG2 + 1;

    sc_state_e   r_state;
    logic [CW-1:0] r_len;
    logic [CW-1:0] r_phase;
    logic [3:0]    r_prob_a;
    logic [3:0]    r_prob_b;
    logic [CW-1:0] w_count;
    logic          w_accept;
    logic          w_cnt_en;

    assign w_accept = (r_state == IDLE) && start_valid;
    assign w_cnt_en = (r_state == COUNT) && dp_bit;

    // rst_n is an active-high reset despite its name.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_state  <= IDLE;
            r_len    <= '0;
            r_phase  <= '0;
            r_prob_a <= '0;
            r_prob_b <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_prob_a <= op_a;
                        r_prob_b <= op_b;
                        r_len    <= CW'(len_decode(len_sel, 32'(MAX_LEN_LOG2)));
                        r_phase  <= '0;
                        r_state  <= SEED;
                    end
                end
                SEED: begin
                    r_phase <= '0;
                    r_state <= FILL;
                end
                FILL: begin
                    if (r_phase == CW'(PIPE_LAT - 1)) begin
                        r_phase <= '0;
                        r_state <= COUNT;
                    end else begin
                        r_phase <= r_phase + CW'(1);
                    end
                end
                COUNT: begin
                    if (r_phase == r_len - CW'(1)) begin
                        r_phase <= '0;
                        r_state <= DONE;
                    end else begin
                        r_phase <= r_phase + CW'(1);
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        r_prob_a <= '0;
                        r_prob_b <= '0;
                        r_state  <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    sc_ones_counter #(
        .W (CW)
    ) u_ones_counter (
        .clk     (clk),
        .rst     (rst_n),
        .i_clr   (w_accept),
        .i_en    (w_cnt_en),
        .o_count (w_count)
    );

    assign start_ready = (r_state == IDLE);
    assign busy        = (r_state != IDLE);
    assign dp_load     = (r_state == SEED);
    assign dp_en       = (r_state == FILL) || (r_state == COUNT);
    assign res_valid   = (r_state == DONE);
    assign res_count   = w_count;
    assign dp_prob_a   = r_prob_a;
    assign dp_prob_b   = r_prob_b;

`ifdef SC_BIPOLAR_DECODE_EN
    // 2*count - L needs one extra bit internally; the result always fits the port.
    logic [CW+1:0] w_bip_wide;
    assign w_bip_wide  = {1'b0, w_count, 1'b0} - {2'b00, r_len};
    assign res_bipolar = signed'(w_bip_wide[CW:0]);
`endif

endmodule

// File: tb/tb_sc_mult_sequencer.sv
// tb/tb_sc_mult_sequencer.sv - self-checking bench for sc_mult_sequencer with a stream-window reference model
module tb_sc_mult_sequencer;

    localparam int TB_PIPE_LAT = 2;
    localparam int TB_MAX_LOG2 = 6;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start_valid;
    logic       start_ready;
    logic [3:0] op_a;
    logic [3:0] op_b;
    logic [1:0] len_sel;
    logic [3:0] dp_prob_a;
    logic [3:0] dp_prob_b;
    logic       dp_load;
    logic       dp_en;
    logic       dp_bit;
    logic       res_valid;
    logic       res_ready;
    logic [6:0] res_count;
    logic       busy;
`ifdef SC_BIPOLAR_DECODE_EN
    logic signed [7:0] res_bipolar;
`endif

    int checks = 0;
    int errors = 0;
    logic bits [0:127];

    always #5 clk = ~clk;

    sc_mult_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .op_a        (op_a),
        .op_b        (op_b),
        .len_sel     (len_sel),
        .dp_prob_a   (dp_prob_a),
        .dp_prob_b   (dp_prob_b),
        .dp_load     (dp_load),
        .dp_en       (dp_en),
        .dp_bit      (dp_bit),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_count   (res_count),
`ifdef SC_BIPOLAR_DECODE_EN
        .res_bipolar (res_bipolar),
`endif
        .busy        (busy)
    );

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int len_of(input int lsel);
        int e;
        e = 3 + lsel;
        if (e > TB_MAX_LOG2) e = TB_MAX_LOG2;
        return 1 << e;
    endfunction

    // Edge k after the accepting edge samples bits[k]; only the L samples after
    // seed (1 edge) and fill (PIPE_LAT edges) count toward the result.
    task automatic run_job(input logic [3:0] a, input logic [3:0] b, input logic [1:0] lsel,
                           input int mode, input int hold);
        int L, lat, cs, ce, exp_cnt;
        bit in_win;
        L       = len_of(int'(lsel));
        lat     = 1 + TB_PIPE_LAT + L;
        cs      = TB_PIPE_LAT + 2;
        ce      = TB_PIPE_LAT + 1 + L;
        exp_cnt = 0;
        for (int k = 0; k < 128; k++) begin
            in_win = (k >= cs) && (k <= ce);
            case (mode)
                1:       bits[k] = 1'b1;
                2:       bits[k] = in_win ? (((k - cs) % 2) == 0) : 1'b1;
                3:       bits[k] = !in_win;
                4:       bits[k] = in_win && ((k - cs) < 6);
                default: bits[k] = 1'($urandom_range(0, 1));
            endcase
            if (in_win && bits[k]) exp_cnt++;
        end

        @(negedge clk);
        chk("ready_before_job", start_ready, 1);
        start_valid = 1'b1;
        op_a        = a;
        op_b        = b;
        len_sel     = lsel;
        dp_bit      = bits[0];
        @(posedge clk);
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            start_valid = (hold > 0);
            op_a        = ~a;
            op_b        = ~b;
            dp_bit      = bits[k];
            chk("res_valid_early", res_valid, 0);
            chk("dp_load", dp_load, (k == 1));
            chk("dp_en", dp_en, (k >= 2));
            chk("dp_prob_a_held", dp_prob_a, a);
            chk("busy_in_job", busy, 1);
            @(posedge clk);
        end
        @(negedge clk);
        dp_bit = 1'b0;
        chk("res_valid_rise", res_valid, 1);
        chk("res_count", res_count, exp_cnt);
        chk("dp_en_done", dp_en, 0);
        chk("dp_prob_b_held", dp_prob_b, b);
`ifdef SC_BIPOLAR_DECODE_EN
        chk("res_bipolar", res_bipolar, 2 * exp_cnt - L);
`endif
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            @(negedge clk);
            chk("res_valid_hold", res_valid, 1);
            chk("res_count_hold", res_count, exp_cnt);
            chk("start_ignored", start_ready, 0);
        end
        start_valid = 1'b0;
        res_ready   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        res_ready = 1'b0;
        chk("res_valid_drop", res_valid, 0);
        chk("ready_after", start_ready, 1);
        chk("busy_after", busy, 0);
        chk("dp_prob_a_idle", dp_prob_a, 0);
    endtask

    initial begin
        rst_n       = 1'b1;
        start_valid = 1'b0;
        op_a        = '0;
        op_b        = '0;
        len_sel     = '0;
        dp_bit      = 1'b0;
        res_ready   = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_start_ready", start_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_count", res_count, 0);
        chk("rst_dp_en", dp_en, 0);
        chk("rst_dp_load", dp_load, 0);
        chk("rst_dp_prob_a", dp_prob_a, 0);
`ifdef SC_BIPOLAR_DECODE_EN
        chk("rst_res_bipolar", res_bipolar, 0);
`endif
        rst_n = 1'b0;

        run_job(4'd15, 4'd15, 2'd0, 1, 0);
        run_job(4'd9, 4'd3, 2'd1, 2, 0);
        run_job(4'd5, 4'd12, 2'd0, 3, 0);
        run_job(4'd7, 4'd8, 2'd0, 1, 5);

        @(negedge clk);
        start_valid = 1'b1;
        op_a        = 4'd10;
        op_b        = 4'd6;
        len_sel     = 2'd0;
        dp_bit      = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("mid_count_busy", busy, 1);
        rst_n = 1'b1;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_dp_en", dp_en, 0);
        chk("abort_res_valid", res_valid, 0);
        chk("abort_res_count", res_count, 0);
        chk("abort_dp_prob_a", dp_prob_a, 0);
        chk("abort_start_ready", start_ready, 1);
        @(negedge clk);
        rst_n  = 1'b0;
        dp_bit = 1'b0;

        run_job(4'd11, 4'd2, 2'd0, 4, 0);
        run_job(4'd1, 4'd14, 2'd0, 3, 0);
        for (int j = 0; j < 6; j++) begin
            run_job(4'($urandom), 4'($urandom), 2'($urandom_range(0, 3)), 0, int'($urandom_range(0, 2)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
